// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
// The state encoding is visible on the loader's debug output.
package loader_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;
    localparam int BYTE_W     = 8;
    localparam int LEN_W      = 12;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_LO  = 4'd1,
        LEN_HI  = 4'd2,
        DATA_LO = 4'd3,
        DATA_HI = 4'd4,
        WRITE   = 4'd5,
        CHECK   = 4'd6,
        RUN     = 4'd7,
        ERROR   = 4'd8
    } loader_state_e;

    // A new load may only be started once the previous one has finished.
    function automatic logic can_restart(input loader_state_e s);
        return (s == IDLE) || (s == RUN) || (s == ERROR);
    endfunction

endpackage

// File: rtl/loader_checksum.sv
// XOR accumulator for the running stream checksum.
// Clear has priority over accept.
module loader_checksum
    import loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [BYTE_W-1:0] sum_o
);

    logic [BYTE_W-1:0] sum_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sum_q <= '0;
        end else if (clear_i) begin
            sum_q <= '0;
        end else if (accept_i) begin
            sum_q <= sum_q ^ byte_i;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction
// memory one word per WRITE cycle, then enables the CPU.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_data_i,
    output logic              byte_ready_o,
    output logic              we_im_o,
    output logic [DATA_W-1:0] code_o,
    output logic [ADDR_W-1:0] immed_address_o,
    output logic              cpu_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [3:0]        dbg_state_o
);

    // The word counter must span the full 12-bit length even when the
    // address bus is narrower.
    localparam int CNT_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;

    // Handshake: a byte transfers on a rising edge where byte_valid_i and
    // byte_ready_o are both high; ready depends only on the current state.
    loader_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [BYTE_W-1:0] lo_q, lo_d;
    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [LEN_W-1:0]  len_next;
    logic [BYTE_W-1:0] ck_sum;
    logic              ck_clear;
    logic              ck_accept;
    logic              fire;
    logic              ready;
    logic              we;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_en;

    assign fire     = byte_valid_i && ready;
    assign len_next = {byte_data_i[3:0], len_q[7:0]};

    loader_checksum u_checksum (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clear_i  (ck_clear),
        .accept_i (ck_accept),
        .byte_i   (byte_data_i),
        .sum_o    (ck_sum)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        ck_clear  = 1'b0;
        ck_accept = 1'b0;
        ready     = 1'b0;
        we        = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        cpu_en    = 1'b0;

        case (state_q)
            IDLE: ;
            LEN_LO: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (fire) begin
                    len_d     = {{(LEN_W-BYTE_W){1'b0}}, byte_data_i};
                    ck_accept = 1'b1;
                    state_d   = LEN_HI;
                end
            end
            LEN_HI: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (fire) begin
                    len_d     = len_next;
                    ck_accept = 1'b1;
                    if ((byte_data_i[7:4] != 4'd0) || (len_next == '0)) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA_LO;
                    end
                end
            end
            DATA_LO: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (fire) begin
                    lo_d      = byte_data_i;
                    ck_accept = 1'b1;
                    state_d   = DATA_HI;
                end
            end
            DATA_HI: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (fire) begin
                    hi_d      = byte_data_i;
                    ck_accept = 1'b1;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                we    = 1'b1;
                busy  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == (CNT_W'(len_q) - CNT_W'(1))) begin
                    state_d = CHECK;
                end else begin
                    state_d = DATA_LO;
                end
            end
            CHECK: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (fire) begin
                    state_d = (byte_data_i == ck_sum) ? RUN : ERROR;
                end
            end
            RUN: begin
                done   = 1'b1;
                cpu_en = 1'b1;
            end
            ERROR: begin
                err = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (start_i && can_restart(state_q)) begin
            state_d  = LEN_LO;
            cnt_d    = '0;
            ck_clear = 1'b1;
        end
    end

    // Outputs decode the current state only, so reset clears them at once.
    assign byte_ready_o    = ready;
    assign we_im_o         = we;
    assign code_o          = we ? DATA_W'({hi_q, lo_q}) : '0;
    assign immed_address_o = we ? cnt_q[ADDR_W-1:0] : '0;
    assign cpu_en_o        = cpu_en;
    assign busy_o          = busy;
    assign done_o          = done;
    assign err_o           = err;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of byte streams with expected
// writes and final status, plus reset-mid-load and reload-in-run sequences.
module tb_program_loader;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int W  = AW + DW;

  typedef struct packed {
    logic [3:0]  n;
    logic [79:0] bytes;
    logic        gap;
    logic        exp_done;
    logic        exp_err;
    logic [1:0]  nw;
    logic [83:0] w;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          we_im;
  logic [DW-1:0] code;
  logic [AW-1:0] addr;
  logic          cpu_en;
  logic          busy;
  logic          done;
  logic          err;
  logic [3:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [W-1:0] exp_q[$];
  vec_t vecs[8];

  program_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .start_i         (start),
    .byte_valid_i    (byte_valid),
    .byte_data_i     (byte_data),
    .byte_ready_o    (byte_ready),
    .we_im_o         (we_im),
    .code_o          (code),
    .immed_address_o (addr),
    .cpu_en_o        (cpu_en),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err),
    .dbg_state_o     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every write strobe is compared against the expected queue
  always @(negedge clk) begin
    if (we_im) begin
      wr_cnt++;
      chk("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
      chk("cpu_en_low_in_write", {31'd0, cpu_en}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h code %0h expected no write", addr, code);
      end else begin
        chk("write_addr_code", 32'({addr, code}), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: got ready 0 expected ready 1 for byte %0h", b);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_stream(input vec_t v);
    for (int i = 0; i < int'(v.n); i++) begin
      send_byte(v.bytes[79-8*i -: 8]);
      if (v.gap) begin
        byte_valid = 1'b0;
        @(negedge clk);
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic check_end(input vec_t v, input int wr_before, input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, v.exp_done});
    chk({tag, "_cpu_en"}, {31'd0, cpu_en}, {31'd0, v.exp_done});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_writes"}, 32'(wr_cnt - wr_before), 32'(v.nw));
    chk({tag, "_exp_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_writes(input vec_t v);
    for (int i = 0; i < int'(v.nw); i++) exp_q.push_back(v.w[83-28*i -: 28]);
  endtask

  initial begin
    int wb;
    //          n     bytes (first byte leftmost)   gap  done err nw writes {addr,code}
    vecs[0] = '{4'd2, 80'h02003412CDAB42000000, 1'b0, 1'b1, 1'b0, 2'd2, 84'h0001234001ABCD0000000};
    vecs[1] = '{4'd7, 80'h02003412CDAB43000000, 1'b0, 1'b0, 1'b1, 2'd2, 84'h0001234001ABCD0000000};
    vecs[2] = '{4'd2, 80'h00100000000000000000, 1'b0, 1'b0, 1'b1, 2'd0, 84'h0};
    vecs[3] = '{4'd2, 80'h00000000000000000000, 1'b0, 1'b0, 1'b1, 2'd0, 84'h0};
    vecs[4] = '{4'd5, 80'h010078562F0000000000, 1'b1, 1'b1, 1'b0, 2'd1, 84'h000567800000000000000};
    vecs[5] = '{4'd9, 80'h03001122334455667400, 1'b1, 1'b1, 1'b0, 2'd3, 84'h000221100144330026655};
    vecs[6] = '{4'd9, 80'h03001122334455667400, 1'b0, 1'b1, 1'b0, 2'd3, 84'h000221100144330026655};
    vecs[7] = '{4'd2, 80'h01F00000000000000000, 1'b0, 1'b0, 1'b1, 2'd0, 84'h0};
    vecs[0].n = 4'd7;

    rst_n = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(dbg_state), 32'd0);
    chk("reset_outputs", {25'd0, byte_ready, we_im, cpu_en, busy, done, err, 1'b0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset_busy", {31'd0, busy}, 32'd0);

    for (int k = 0; k < 8; k++) begin
      pulse_start();
      chk($sformatf("v%0d_start_busy", k), {31'd0, busy}, 32'd1);
      chk($sformatf("v%0d_start_clears", k), {30'd0, err, cpu_en}, 32'd0);
      wb = wr_cnt;
      push_writes(vecs[k]);
      run_stream(vecs[k]);
      check_end(vecs[k], wb, $sformatf("v%0d", k));
    end

    // reset mid-load: first word written, reset lands after 3 data bytes
    pulse_start();
    wb = wr_cnt;
    exp_q.push_back(28'h0001234);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'hCD);
    chk("midload_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_state", 32'(dbg_state), 32'd0);
    chk("async_reset_outputs", {25'd0, byte_ready, we_im, cpu_en, busy, done, err, 1'b0}, 32'd0);
    chk("async_reset_bus", 32'({addr, code}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    byte_data = 8'hAB;
    repeat (4) @(negedge clk);
    byte_valid = 1'b0;
    chk("no_write_after_reset", 32'(wr_cnt - wb), 32'd1);
    chk("idle_after_midload_reset", 32'(dbg_state), 32'd0);
    pulse_start();
    wb = wr_cnt;
    push_writes(vecs[0]);
    run_stream(vecs[0]);
    check_end(vecs[0], wb, "fresh_load");

    // reload while running
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("reload_cpu_en_falls", {31'd0, cpu_en}, 32'd0);
    chk("reload_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    wb = wr_cnt;
    push_writes(vecs[4]);
    run_stream(vecs[4]);
    check_end(vecs[4], wb, "reload");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; both are listed first below.
REQ-002 Parameter ADDR_W, default 12: instruction-memory address width.
REQ-003 Parameter DATA_W, default 16: instruction word width, fixed at two bytes.
REQ-004 clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst_n_i  in  1  asynchronous active-low reset.
REQ-006 start_i  in  1  single-cycle pulse that begins a load.
REQ-007 byte_valid_i  in  1  byte_data_i holds a valid byte.
REQ-008 byte_data_i  in  8  serial program stream byte.
REQ-009 byte_ready_o  out  1  loader accepts a byte; a transfer occurs when valid and ready are both high.
REQ-010 we_im_o  out  1  instruction-memory write strobe (drives the CPU we_im_i input).
REQ-011 code_o  out  DATA_W  instruction word to write (drives code_i).
REQ-012 immed_address_o  out  ADDR_W  write address (drives immed_address_i).
REQ-013 cpu_en_o  out  1  CPU enable (drives EN_i).
REQ-014 busy_o, done_o, err_o  out  1 each  loading, loaded and running, failed.

Function
REQ-015 Stream format SHALL be: LEN_LO, LEN_HI, then LEN words sent low byte first, then one checksum byte.
REQ-016 The checksum SHALL equal the XOR of every preceding byte in the stream, including both length bytes.
REQ-017 States SHALL be IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHECK, RUN and ERROR.
REQ-018 On start_i, IDLE, ERROR or RUN SHALL go to LEN_LO, clear the word counter, checksum, err_o and cpu_en_o; start_i is ignored in all other states.
REQ-019 byte_ready_o SHALL be high only in LEN_LO, LEN_HI, DATA_LO, DATA_HI and CHECK; each accepted byte advances the state one step.
REQ-020 In LEN_HI, if LEN_HI[7:4] != 0 or the 12-bit length is 0, the next state SHALL be ERROR; otherwise it SHALL be DATA_LO.
REQ-021 After DATA_HI is accepted, the FSM SHALL spend exactly one cycle in WRITE with we_im_o=1, code_o={hi,lo} and immed_address_o=word counter.
REQ-022 In that cycle the counter SHALL increment; if the counter equals LEN-1, the next state SHALL be CHECK, else DATA_LO.
REQ-023 byte_ready_o SHALL be low in WRITE, so a byte held valid through WRITE is accepted in the following DATA_LO cycle with no loss.
REQ-024 In CHECK, a matching checksum byte SHALL go to RUN; a mismatch SHALL go to ERROR.
REQ-025 RUN SHALL hold cpu_en_o=1 and done_o=1 until start_i.
REQ-026 ERROR SHALL hold err_o=1 and cpu_en_o=0 until start_i.
REQ-027 busy_o SHALL be high in every state from LEN_LO through CHECK.
REQ-028 cpu_en_o SHALL never be high while we_im_o is high.
REQ-029 we_im_o SHALL be high only in WRITE; code_o and immed_address_o are don't-care when we_im_o=0.

Reset
REQ-030 Asserting rst_n_i low at any time, including mid-load, SHALL immediately force IDLE with all outputs 0, counter 0 and checksum 0.
REQ-031 Reset SHALL produce no partial write; no write strobe is issued until a new start_i.

Structure
REQ-032 A shared package loader_pkg SHALL hold the state enum, ADDR_W and DATA_W defaults, and a BYTE_W=8 constant.
REQ-033 One sub-module, loader_checksum, SHALL be used: an XOR accumulator with clear and accept inputs and an 8-bit output.

Verification
REQ-034 Good load: start, bytes 02 00 34 12 CD AB 42 -> writes addr0=0x1234 and addr1=0xABCD, one cycle each; then cpu_en_o=1 and done_o=1.
REQ-035 Bad checksum: same stream ending 43 -> two writes, then err_o=1 and cpu_en_o=0; a later start_i clears err_o.
REQ-036 Bad length: bytes 00 10 -> ERROR after the second byte, no writes; length 00 00 -> also ERROR.
REQ-037 Backpressure: byte_valid_i held high continuously -> byte_ready_o low in every WRITE cycle, all bytes consumed exactly once, addresses 0..N-1 contiguous.
REQ-038 Reset mid-load: rst_n_i low after 3 data bytes -> all outputs 0 asynchronously; a fresh load after reset succeeds from address 0.
REQ-039 Reload in RUN: start_i while running -> cpu_en_o falls next cycle, and a new program is loaded and re-enables the CPU.
